// File: rtl/bank_router_pkg.sv
// Shared packet types and default sizing for the bank crossbar router.
package bank_router_pkg;

  localparam int NUM_BANKS         = 4;
  localparam int ROUTER_FIFO_DEPTH = 4;
  localparam int BANK_IDX_W        = $clog2(NUM_BANKS);

  localparam int COORD_W = 4;
  localparam int DATA_W  = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } addr_t;

  typedef struct packed {
    addr_t             addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Owning bank of a packet: the low bits of the x coordinate; y and z are bank-internal.
  function automatic logic [BANK_IDX_W-1:0] bank_of(pkt_t p);
    return p.addr.x[BANK_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Single-clock synchronous FIFO of packets; one per router input port.
module router_fifo
  import bank_router_pkg::*;
#(
  parameter int  DEPTH = ROUTER_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  pkt_t             pkt_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output pkt_t             head_o,
  output logic [CNT_W-1:0] count_o
);

  pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q + PTR_W'(do_push);
    rd_d  = rd_q + PTR_W'(do_pop);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the count gates every read, so stale entries are never seen.
    if (do_push) mem_q[wr_q] <= pkt_i;
  end

endmodule

// File: rtl/bank_router.sv
// Crossbar between banks: per-input FIFOs, per-output round-robin arbiter and registered slot.
module bank_router
  import bank_router_pkg::*;
#(
  parameter int  NUM_BANKS  = bank_router_pkg::NUM_BANKS,
  parameter int  FIFO_DEPTH = ROUTER_FIFO_DEPTH,
  localparam int BANK_IDX_W = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] bank_valid_in,
  output logic [NUM_BANKS-1:0] bank_ready_in,
  input  pkt_t                 bank_in_pkt    [NUM_BANKS],
  output logic [NUM_BANKS-1:0] bank_valid_out,
  input  logic [NUM_BANKS-1:0] bank_ready_out,
  output pkt_t                 bank_out_pkt   [NUM_BANKS],
  output logic                 idle,
  output logic                 err_bad_dest
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_BANKS-1:0]  fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_busy, bad_head;
  pkt_t                  fifo_head [NUM_BANKS];
  logic [CNT_W-1:0]      fifo_cnt  [NUM_BANKS];
  logic [BANK_IDX_W-1:0] head_dest [NUM_BANKS];

  logic [NUM_BANKS-1:0]  valid_q, valid_d;
  pkt_t                  pkt_q [NUM_BANKS];
  pkt_t                  pkt_d [NUM_BANKS];
  logic [BANK_IDX_W-1:0] rr_q  [NUM_BANKS];
  logic [BANK_IDX_W-1:0] rr_d  [NUM_BANKS];
  logic                  err_q, err_d;

  // Ready comes from the registered count only, never from any valid.
  assign bank_ready_in = ~fifo_full;
  assign fifo_push     = bank_valid_in & bank_ready_in;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_in
    router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[i]),
      .pkt_i   (bank_in_pkt[i]),
      .full_o  (fifo_full[i]),
      .pop_i   (fifo_pop[i]),
      .empty_o (fifo_empty[i]),
      .head_o  (fifo_head[i]),
      .count_o (fifo_cnt[i])
    );
    assign head_dest[i] = fifo_head[i].addr.x[BANK_IDX_W-1:0];
    assign bad_head[i]  = !fifo_empty[i] && (int'(head_dest[i]) >= NUM_BANKS);
    assign fifo_busy[i] = (fifo_cnt[i] != '0);
  end

  // Per-output round-robin grant, slot load and head dequeue; bad heads are dropped.
  always_comb begin
    logic                  found;
    logic [BANK_IDX_W-1:0] win, cand;
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    fifo_pop = bad_head;
    err_d    = err_q || (|bad_head);
    for (int o = 0; o < NUM_BANKS; o++) begin
      found = 1'b0;
      win   = rr_q[o];
      for (int k = 1; k <= NUM_BANKS; k++) begin
        cand = BANK_IDX_W'((int'(rr_q[o]) + k) % NUM_BANKS);
        if (!found && !fifo_empty[cand] && head_dest[cand] == BANK_IDX_W'(o)) begin
          found = 1'b1;
          win   = cand;
        end
      end
      valid_d[o] = valid_q[o] && !bank_ready_out[o];
      pkt_d[o]   = pkt_q[o];
      rr_d[o]    = rr_q[o];
      if ((!valid_q[o] || bank_ready_out[o]) && found) begin
        valid_d[o]    = 1'b1;
        pkt_d[o]      = fifo_head[win];
        rr_d[o]       = win;
        fifo_pop[win] = 1'b1;
      end
    end
  end

  // Output slots, round-robin pointers and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int o = 0; o < NUM_BANKS; o++) begin
        pkt_q[o] <= '0;
        rr_q[o]  <= BANK_IDX_W'(NUM_BANKS - 1);
      end
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign bank_valid_out = valid_q;
  assign bank_out_pkt   = pkt_q;
  assign err_bad_dest   = err_q;
  assign idle           = !(|fifo_busy) && !(|valid_q);

endmodule

// File: tb/tb_bank_router.sv
// Self-checking bench for bank_router: directed scenarios plus randomized traffic
// against a queue-based reference model (4-bank and 3-bank instances).
module tb_bank_router;
  import bank_router_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mn    = 4;   // which instance (4 or 3 banks) is being exercised

  logic [3:0] d_valid, d_rdy;
  pkt_t       d_pkt [4];

  logic [3:0] v4, rdy4, ready4, vout4;
  pkt_t       out4 [4];
  logic       idle4, err4;
  logic [2:0] v3, rdy3, ready3, vout3;
  pkt_t       in3  [3];
  pkt_t       out3 [3];
  logic       idle3, err3;

  assign v4   = (mn == 4) ? d_valid : 4'h0;
  assign rdy4 = (mn == 4) ? d_rdy : 4'hF;
  assign v3   = (mn == 3) ? d_valid[2:0] : 3'h0;
  assign rdy3 = (mn == 3) ? d_rdy[2:0] : 3'h7;
  always_comb for (int i = 0; i < 3; i++) in3[i] = d_pkt[i];

  bank_router #(.NUM_BANKS(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst(rst), .bank_valid_in(v4), .bank_ready_in(ready4), .bank_in_pkt(d_pkt),
    .bank_valid_out(vout4), .bank_ready_out(rdy4), .bank_out_pkt(out4),
    .idle(idle4), .err_bad_dest(err4));

  bank_router #(.NUM_BANKS(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .rst(rst), .bank_valid_in(v3), .bank_ready_in(ready3), .bank_in_pkt(in3),
    .bank_valid_out(vout3), .bank_ready_out(rdy3), .bank_out_pkt(out3),
    .idle(idle3), .err_bad_dest(err3));

  // Observed outputs of the active instance, sampled 1 time unit after each rising edge.
  logic [3:0] o_valid, o_ready;
  pkt_t       o_pkt [4];
  logic       o_idle, o_err;

  // Reference model: a queue per input FIFO, a slot per output, a last-winner per output.
  pkt_t mq [4][$];
  bit   [3:0] mv;
  pkt_t mp  [4];
  int   mrr [4];
  bit   merr;

  function automatic int dst(pkt_t p);
    return int'(p.addr.x) % 4;   // both instances use a 2-bit bank index
  endfunction

  function automatic pkt_t mk(int x, int data);
    pkt_t p;
    p.addr.x = COORD_W'(x);
    p.addr.y = COORD_W'($urandom_range(0, 15));
    p.addr.z = COORD_W'($urandom_range(0, 15));
    p.data   = DATA_W'(data);
    return p;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < mn; i++) if (mq[i].size() != 0 || mv[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mp[i]  = '0;
      mrr[i] = mn - 1;
    end
    mv   = '0;
    merr = 1'b0;
  endtask

  task automatic model_step();
    int win [4];
    bit rdy [4];
    bit popq [4];
    for (int i = 0; i < mn; i++) begin
      rdy[i]  = mq[i].size() < DEPTH;
      popq[i] = 1'b0;
      if (mq[i].size() > 0 && dst(mq[i][0]) >= mn) begin
        popq[i] = 1'b1;
        merr    = 1'b1;
      end
    end
    for (int o = 0; o < mn; o++) begin
      win[o] = -1;
      for (int k = 1; k <= mn; k++) begin
        int idx = (mrr[o] + k) % mn;
        if (win[o] < 0 && mq[idx].size() > 0 && dst(mq[idx][0]) == o) win[o] = idx;
      end
      if ((!mv[o] || d_rdy[o]) && win[o] >= 0) begin
        mp[o]         = mq[win[o]][0];
        mv[o]         = 1'b1;
        mrr[o]        = win[o];
        popq[win[o]]  = 1'b1;
      end else if (d_rdy[o]) begin
        mv[o] = 1'b0;
      end
    end
    for (int i = 0; i < mn; i++) begin
      if (popq[i]) void'(mq[i].pop_front());
      if (d_valid[i] && rdy[i]) mq[i].push_back(d_pkt[i]);
    end
  endtask

  task automatic sample();
    o_valid = '0;
    o_ready = '0;
    for (int i = 0; i < 4; i++) o_pkt[i] = '0;
    if (mn == 4) begin
      o_valid = vout4;
      o_ready = ready4;
      for (int i = 0; i < 4; i++) o_pkt[i] = out4[i];
      o_idle = idle4;
      o_err  = err4;
    end else begin
      o_valid = {1'b0, vout3};
      o_ready = {1'b0, ready3};
      for (int i = 0; i < 3; i++) o_pkt[i] = out3[i];
      o_idle = idle3;
      o_err  = err3;
    end
  endtask

  // One clock: advance the model with the current inputs, then sample the DUT.
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic apply_reset();
    d_valid = '0;
    d_rdy   = 4'hF;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    mn = 4;
    apply_reset();
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL reset_valid4: got %h want 0", o_valid); end
    n_cmp++; if (o_ready !== 4'hF) begin n_bad++; $display("FAIL reset_ready4: got %h want f", o_ready); end
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle4: got %b want 1", o_idle); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err4: got %b want 0", o_err); end
    for (int o = 0; o < 4; o++) begin
      n_cmp++; if (o_pkt[o] !== '0) begin n_bad++; $display("FAIL reset_pkt%0d: got %h want 0", o, o_pkt[o]); end
    end
    n_cmp++; if (vout3 !== 3'h0 || ready3 !== 3'h7 || idle3 !== 1'b1 || err3 !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut3: got v=%h r=%h i=%b e=%b want v=0 r=7 i=1 e=0", vout3, ready3, idle3, err3);
    end
  endtask

  task automatic test_single();
    pkt_t p;
    apply_reset();
    p = mk(2, 16'hA5A5);
    d_valid = 4'b0001;
    d_pkt[0] = p;
    tick();                       // accepted at this edge
    d_valid = '0;
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL single_c1_valid: got %h want 0", o_valid); end
    n_cmp++; if (o_idle !== 1'b0) begin n_bad++; $display("FAIL single_c1_idle: got %b want 0", o_idle); end
    tick();
    n_cmp++; if (o_valid !== 4'b0100) begin n_bad++; $display("FAIL single_c2_valid: got %h want 4", o_valid); end
    n_cmp++; if (o_pkt[2] !== p) begin n_bad++; $display("FAIL single_c2_pkt: got %h want %h", o_pkt[2], p); end
    n_cmp++; if (o_idle !== 1'b0) begin n_bad++; $display("FAIL single_c2_idle: got %b want 0", o_idle); end
    tick();
    n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL single_c3_valid: got %h want 0", o_valid); end
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL single_c3_idle: got %b want 1", o_idle); end
  endtask

  task automatic test_contention();
    int order [3] = '{0, 1, 3};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) d_pkt[i] = mk(1, 16'h100 + r * 16 + i);
      d_valid = 4'b1011;
      tick();
      d_valid = '0;
      tick();
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (o_valid !== 4'b0010 || o_pkt[1].data !== DATA_W'(16'h100 + r * 16 + order[j])) begin
          n_bad++; $display("FAIL contention_r%0d_slot%0d: got v=%h d=%h want v=2 d=%h",
                            r, j, o_valid, o_pkt[1].data, 16'h100 + r * 16 + order[j]);
        end
        tick();
      end
      n_cmp++; if (o_valid !== 4'h0) begin n_bad++; $display("FAIL contention_r%0d_done: got %h want 0", r, o_valid); end
    end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    bit   acc;
    pkt_t held;
    logic [DATA_W-1:0] got [$];
    apply_reset();
    d_rdy = 4'b1101;
    held  = '0;
    for (int c = 0; c < 12; c++) begin
      d_valid[0] = (sent < 6);
      d_pkt[0]   = mk(1, 16'h300 + sent);
      acc        = d_valid[0] && o_ready[0];
      tick();
      if (acc) sent++;
      if (c == 6) held = o_pkt[1];
    end
    n_cmp++; if (sent != 5) begin n_bad++; $display("FAIL bp_accepted: got %0d want 5", sent); end
    n_cmp++; if (o_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_ready0: got %b want 0", o_ready[0]); end
    n_cmp++; if (o_valid[1] !== 1'b1 || o_pkt[1] !== held || o_pkt[1].data !== 16'h300) begin
      n_bad++; $display("FAIL bp_held: got v=%b pkt=%h want v=1 pkt=%h data=300", o_valid[1], o_pkt[1], held);
    end
    d_rdy = 4'hF;
    for (int c = 0; c < 20; c++) begin
      d_valid[0] = (sent < 6);
      d_pkt[0]   = mk(1, 16'h300 + sent);
      acc        = d_valid[0] && o_ready[0];
      if (o_valid[1]) got.push_back(o_pkt[1].data);
      tick();
      if (acc) sent++;
    end
    d_valid = '0;
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL bp_delivered: got %0d want 6", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_cmp++; if (got[k] !== DATA_W'(16'h300 + k)) begin
        n_bad++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], 16'h300 + k);
      end
    end
  endtask

  task automatic test_permutation();
    int nxt [4] = '{0, 0, 0, 0};
    int delivered = 0;
    int src;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        d_valid = 4'hF;
        for (int i = 0; i < 4; i++) d_pkt[i] = mk((i + 1) % 4, 16'h400 + c * 4 + i);
        n_cmp++; if (o_ready !== 4'hF) begin n_bad++; $display("FAIL perm_stall_c%0d: got %h want f", c, o_ready); end
      end else begin
        d_valid = '0;
      end
      for (int o = 0; o < 4; o++) begin
        if (o_valid[o]) begin
          src = (o + 3) % 4;
          n_cmp++; if (o_pkt[o].data !== DATA_W'(16'h400 + nxt[o] * 4 + src)) begin
            n_bad++; $display("FAIL perm_data_o%0d: got %h want %h", o, o_pkt[o].data, 16'h400 + nxt[o] * 4 + src);
          end
          nxt[o]++;
          delivered++;
        end
      end
      tick();
      if (c >= 1 && c <= 20) begin
        n_cmp++; if (o_valid !== 4'hF) begin n_bad++; $display("FAIL perm_valid_c%0d: got %h want f", c, o_valid); end
      end
    end
    n_cmp++; if (delivered != 80) begin n_bad++; $display("FAIL perm_count: got %0d want 80", delivered); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    d_rdy = 4'b1011;
    d_valid = 4'b0001;
    d_pkt[0] = mk(2, 16'h600);
    tick();
    d_valid = 4'b1011;
    for (int i = 0; i < 4; i++) d_pkt[i] = mk(2, 16'h610 + i);
    tick();
    d_valid = '0;
    n_cmp++; if (o_valid !== 4'b0100 || o_idle !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_pre: got v=%h idle=%b want v=4 idle=0", o_valid, o_idle);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (o_valid !== 4'h0 || o_ready !== 4'hF || o_idle !== 1'b1 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_post: got v=%h r=%h i=%b e=%b want v=0 r=f i=1 e=0", o_valid, o_ready, o_idle, o_err);
    end
    d_rdy = 4'hF;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (o_valid !== 4'h0 || o_idle !== 1'b1) begin
        n_bad++; $display("FAIL rstmid_stale_c%0d: got v=%h idle=%b want v=0 idle=1", c, o_valid, o_idle);
      end
    end
  endtask

  task automatic test_bad_dest();
    mn = 3;
    apply_reset();
    d_valid = 4'b0010;
    d_pkt[1] = mk(3, 16'h0BAD);
    tick();
    d_valid = '0;
    n_cmp++; if (o_err !== 1'b0 || o_idle !== 1'b0) begin
      n_bad++; $display("FAIL bad_c1: got err=%b idle=%b want err=0 idle=0", o_err, o_idle);
    end
    for (int c = 2; c < 6; c++) begin
      tick();
      n_cmp++; if (o_err !== 1'b1 || o_valid !== 4'h0 || o_idle !== 1'b1) begin
        n_bad++; $display("FAIL bad_c%0d: got err=%b v=%h idle=%b want err=1 v=0 idle=1", c, o_err, o_valid, o_idle);
      end
    end
  endtask

  task automatic test_random(int cycles);
    int x;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) begin
        d_valid[i] = ($urandom % 3) != 0;
        d_rdy[i]   = ($urandom % 4) != 0;
        if (mn == 4)                x = $urandom_range(0, 15);
        else if ($urandom % 16 == 0) x = 3;
        else                        x = $urandom_range(0, 2) + 4 * $urandom_range(0, 3);
        d_pkt[i] = mk(x, $urandom);
      end
      tick();
      for (int o = 0; o < mn; o++) begin
        n_cmp++; if (o_valid[o] !== mv[o]) begin
          n_bad++; $display("FAIL rnd%0d_valid_o%0d_c%0d: got %b want %b", mn, o, c, o_valid[o], mv[o]);
        end
        if (mv[o]) begin
          n_cmp++; if (o_pkt[o] !== mp[o]) begin
            n_bad++; $display("FAIL rnd%0d_pkt_o%0d_c%0d: got %h want %h", mn, o, c, o_pkt[o], mp[o]);
          end
        end
        n_cmp++; if (o_ready[o] !== (mq[o].size() < DEPTH)) begin
          n_bad++; $display("FAIL rnd%0d_ready_i%0d_c%0d: got %b want %b", mn, o, c, o_ready[o], mq[o].size() < DEPTH);
        end
      end
      n_cmp++; if (o_idle !== model_idle() || o_err !== merr) begin
        n_bad++; $display("FAIL rnd%0d_flags_c%0d: got idle=%b err=%b want idle=%b err=%b", mn, c, o_idle, o_err, model_idle(), merr);
      end
    end
    d_valid = '0;
    d_rdy   = 4'hF;
    for (int c = 0; c < 40 && !o_idle; c++) tick();
    n_cmp++; if (o_idle !== 1'b1 || !model_idle()) begin
      n_bad++; $display("FAIL rnd%0d_drain: got idle=%b model_idle=%b want 1/1", mn, o_idle, model_idle());
    end
  endtask

  initial begin
    rst     = 1'b1;
    d_valid = '0;
    d_rdy   = 4'hF;
    for (int i = 0; i < 4; i++) d_pkt[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_permutation();
    test_reset_mid();
    test_random(400);
    test_bad_dest();
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule
